// File: rtl/axi_w_router_if.sv
// Signal bundle between master M1, the AW stage and the three W-channel slaves.
interface axi_w_router_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  // AW-stage observation
  logic              aw_valid;
  logic              aw_ready;
  logic [2:0]        aw_sel;
  logic [LEN_W-1:0]  aw_len;

  // Master-side W channel
  logic [DATA_W-1:0] WDATA_M1;
  logic [STRB_W-1:0] WSTRB_M1;
  logic              WLAST_M1;
  logic              WVALID_M1;
  logic              WREADY_M1;

  // Slave-side W channels
  logic [DATA_W-1:0] WDATA_S0, WDATA_S1, WDATA_S2;
  logic [STRB_W-1:0] WSTRB_S0, WSTRB_S1, WSTRB_S2;
  logic              WLAST_S0, WLAST_S1, WLAST_S2;
  logic              WVALID_S0, WVALID_S1, WVALID_S2;
  logic              WREADY_S0, WREADY_S1, WREADY_S2;

  // B channel, observed only
  logic              BVALID_S0, BVALID_S1, BVALID_S2;
  logic              BREADY_M1;

  logic              wlast_err;

  // Router side
  modport slave (
    input  aw_valid, aw_ready, aw_sel, aw_len,
    input  WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
    output WREADY_M1,
    output WDATA_S0, WDATA_S1, WDATA_S2,
    output WSTRB_S0, WSTRB_S1, WSTRB_S2,
    output WLAST_S0, WLAST_S1, WLAST_S2,
    output WVALID_S0, WVALID_S1, WVALID_S2,
    input  WREADY_S0, WREADY_S1, WREADY_S2,
    input  BVALID_S0, BVALID_S1, BVALID_S2, BREADY_M1,
    output wlast_err
  );

  // Environment side (master, AW stage and slaves)
  modport master (
    output aw_valid, aw_ready, aw_sel, aw_len,
    output WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
    input  WREADY_M1,
    input  WDATA_S0, WDATA_S1, WDATA_S2,
    input  WSTRB_S0, WSTRB_S1, WSTRB_S2,
    input  WLAST_S0, WLAST_S1, WLAST_S2,
    input  WVALID_S0, WVALID_S1, WVALID_S2,
    output WREADY_S0, WREADY_S1, WREADY_S2,
    output BVALID_S0, BVALID_S1, BVALID_S2, BREADY_M1,
    input  wlast_err
  );
endinterface

// File: rtl/axi_w_router.sv
// W-channel router for master M1: latches slave/length on AW, steers W beats
// to one slave with counter-generated WLAST, and holds the route until B.
module axi_w_router #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  axi_w_router_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Illegal or empty decodes fall back to the default slave S2.
  function automatic logic [2:0] sel_decode(input logic [2:0] s);
    if (s == 3'b001 || s == 3'b010 || s == 3'b100) return s;
    else return 3'b100;
  endfunction

  logic [1:0]       state;
  logic [2:0]       sel_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             err_q;

  logic             aw_fire;
  logic             last_beat;
  logic             wready_m1;
  logic             beat;
  logic             b_done;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  assign aw_fire   = bus.aw_valid & bus.aw_ready;
  assign last_beat = (cnt == len_q);
  assign wready_m1 = (state == DATA) &
                     ((sel_q[0] & bus.WREADY_S0) |
                      (sel_q[1] & bus.WREADY_S1) |
                      (sel_q[2] & bus.WREADY_S2));
  assign beat      = bus.WVALID_M1 & wready_m1;
  assign b_done    = bus.BREADY_M1 &
                     ((sel_q[0] & bus.BVALID_S0) |
                      (sel_q[1] & bus.BVALID_S1) |
                      (sel_q[2] & bus.BVALID_S2));
  assign wdata     = bus.WDATA_M1;
  assign wstrb     = bus.WSTRB_M1;

  assign bus.WREADY_M1 = wready_m1;
  assign bus.wlast_err = err_q;

  // Steer the master W channel to the latched slave only while in DATA.
  always_comb begin
    bus.WDATA_S0  = '0;
    bus.WDATA_S1  = '0;
    bus.WDATA_S2  = '0;
    bus.WSTRB_S0  = '0;
    bus.WSTRB_S1  = '0;
    bus.WSTRB_S2  = '0;
    bus.WLAST_S0  = 1'b0;
    bus.WLAST_S1  = 1'b0;
    bus.WLAST_S2  = 1'b0;
    bus.WVALID_S0 = 1'b0;
    bus.WVALID_S1 = 1'b0;
    bus.WVALID_S2 = 1'b0;
    if (state == DATA) begin
      if (sel_q[0]) begin
        bus.WDATA_S0  = wdata;
        bus.WSTRB_S0  = wstrb;
        bus.WLAST_S0  = last_beat;
        bus.WVALID_S0 = bus.WVALID_M1;
      end
      if (sel_q[1]) begin
        bus.WDATA_S1  = wdata;
        bus.WSTRB_S1  = wstrb;
        bus.WLAST_S1  = last_beat;
        bus.WVALID_S1 = bus.WVALID_M1;
      end
      if (sel_q[2]) begin
        bus.WDATA_S2  = wdata;
        bus.WSTRB_S2  = wstrb;
        bus.WLAST_S2  = last_beat;
        bus.WVALID_S2 = bus.WVALID_M1;
      end
    end
  end

  // Burst control: capture route on AW, count beats, release on B.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      len_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= beat & (bus.WLAST_M1 != last_beat);
      case (state)
        IDLE: begin
          if (aw_fire) begin
            sel_q <= sel_decode(bus.aw_sel);
            len_q <= bus.aw_len;
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (last_beat) begin
              state <= RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (b_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_w_router.sv
// Cycle-by-cycle directed vector bench for axi_w_router.
module tb_axi_w_router;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_w_router_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

  axi_w_router #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              chk;
    logic              r;
    logic              awv;
    logic              awr;
    logic [2:0]        sel;
    logic [LEN_W-1:0]  len;
    logic              wv;
    logic              wl;
    logic [DATA_W-1:0] wd;
    logic [2:0]        wr;
    logic [2:0]        bv;
    logic              br;
    logic              e_wr;
    logic [2:0]        e_route;
    logic [2:0]        e_vld;
    logic [2:0]        e_last;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int chk, input int r, input int awv, input int awr,
                     input int sel, input int len, input int wv, input int wl,
                     input logic [DATA_W-1:0] wd, input int wr, input int bv,
                     input int br, input int e_wr, input int e_route,
                     input int e_vld, input int e_last, input int e_err);
    vec_t v;
    v.chk = 1'(chk);   v.r = 1'(r);     v.awv = 1'(awv);  v.awr = 1'(awr);
    v.sel = 3'(sel);   v.len = LEN_W'(len);
    v.wv = 1'(wv);     v.wl = 1'(wl);   v.wd = wd;
    v.wr = 3'(wr);     v.bv = 3'(bv);   v.br = 1'(br);
    v.e_wr = 1'(e_wr); v.e_route = 3'(e_route); v.e_vld = 3'(e_vld);
    v.e_last = 3'(e_last); v.e_err = 1'(e_err);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [STRB_W-1:0] strb_of(input logic [DATA_W-1:0] d);
    return d[STRB_W-1:0] ^ 4'hA;
  endfunction

  initial begin
    logic [3*DATA_W-1:0] exp_d;
    logic [3*STRB_W-1:0] exp_s;
    vec_t v;

    // chk rst awv awr sel len wv wl wd wr bv br | e_wr route vld last err
    // Reset, then WVALID held in IDLE must stall
    add(0,1,0,0,'b000,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,1,0,0,'b000,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'h11111111,'b111,'b000,0, 0,'b000,'b000,'b000,0);
    // Single beat to S0
    add(1,0,1,1,'b001,0,1,1,32'hDEADBEEF,'b001,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'hDEADBEEF,'b001,'b000,0, 1,'b001,'b001,'b001,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b001,'b000,1, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b001,1, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'h22222222,'b001,'b000,0, 0,'b000,'b000,'b000,0);
    // Four-beat burst to S1 with toggling ready
    add(1,0,1,1,'b010,3,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'hA0A0A0A0,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,0,0,32'hA1A1A1A1,'b010,'b000,0, 1,'b010,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'hA1A1A1A1,'b000,'b000,0, 0,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'hA1A1A1A1,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'hA2A2A2A2,'b000,'b000,0, 0,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'hA2A2A2A2,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'hA3A3A3A3,'b000,'b000,0, 0,'b010,'b010,'b010,0);
    add(1,0,0,0,'b000,0,1,1,32'hA3A3A3A3,'b010,'b000,0, 1,'b010,'b010,'b010,0);
    add(1,0,0,0,'b000,0,1,0,32'h33333333,'b010,'b001,1, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b010,'b010,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b010,'b010,1, 0,'b000,'b000,'b000,0);
    // Bad decodes 000 and 011 fall back to S2
    add(1,0,1,1,'b000,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'h55555555,'b011,'b000,0, 0,'b100,'b100,'b100,0);
    add(1,0,0,0,'b000,0,1,1,32'h55555555,'b100,'b000,0, 1,'b100,'b100,'b100,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b100,1, 0,'b000,'b000,'b000,0);
    add(1,0,1,1,'b011,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'h66666666,'b111,'b000,0, 1,'b100,'b100,'b100,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b100,1, 0,'b000,'b000,'b000,0);
    // WLAST asserted early on a two-beat burst
    add(1,0,1,1,'b001,1,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'h77777777,'b001,'b000,0, 1,'b001,'b001,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'h78787878,'b001,'b000,0, 1,'b001,'b001,'b001,1);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b001,1, 0,'b000,'b000,'b000,0);
    // Reset in the middle of a len=7 burst, then a fresh single beat
    add(1,0,1,1,'b010,7,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'h90909090,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'h91919191,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,1,0,0,'b000,0,1,0,32'h92929292,'b010,'b000,0, 1,'b010,'b010,'b000,0);
    add(1,0,0,0,'b000,0,1,0,32'h93939393,'b111,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,1,1,'b001,0,0,0,32'h0,       'b000,'b000,0, 0,'b000,'b000,'b000,0);
    add(1,0,0,0,'b000,0,1,1,32'hA5A5A5A5,'b001,'b000,0, 1,'b001,'b001,'b001,0);
    add(1,0,0,0,'b000,0,0,0,32'h0,       'b000,'b001,1, 0,'b000,'b000,'b000,0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst           = v.r;
      bus.aw_valid  = v.awv;
      bus.aw_ready  = v.awr;
      bus.aw_sel    = v.sel;
      bus.aw_len    = v.len;
      bus.WVALID_M1 = v.wv;
      bus.WLAST_M1  = v.wl;
      bus.WDATA_M1  = v.wd;
      bus.WSTRB_M1  = strb_of(v.wd);
      bus.WREADY_S0 = v.wr[0];
      bus.WREADY_S1 = v.wr[1];
      bus.WREADY_S2 = v.wr[2];
      bus.BVALID_S0 = v.bv[0];
      bus.BVALID_S1 = v.bv[1];
      bus.BVALID_S2 = v.bv[2];
      bus.BREADY_M1 = v.br;
      #1;
      if (v.chk) begin
        for (int n = 0; n < 3; n++) begin
          exp_d[n*DATA_W +: DATA_W] = v.e_route[n] ? v.wd : '0;
          exp_s[n*STRB_W +: STRB_W] = v.e_route[n] ? strb_of(v.wd) : '0;
        end
        check("wready_m1", i, 128'(bus.WREADY_M1), 128'(v.e_wr));
        check("wvalid_s", i, 128'({bus.WVALID_S2, bus.WVALID_S1, bus.WVALID_S0}), 128'(v.e_vld));
        check("wlast_s", i, 128'({bus.WLAST_S2, bus.WLAST_S1, bus.WLAST_S0}), 128'(v.e_last));
        check("wdata_s", i, 128'({bus.WDATA_S2, bus.WDATA_S1, bus.WDATA_S0}), 128'(exp_d));
        check("wstrb_s", i, 128'({bus.WSTRB_S2, bus.WSTRB_S1, bus.WSTRB_S0}), 128'(exp_s));
        check("wlast_err", i, 128'(bus.wlast_err), 128'(v.e_err));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
